// File: rtl/disp_arbiter.sv
// Shares the 8-digit display among NREQ requesters; 1-cycle req->gnt latency, grant holds HOLD_CYCLES, others wait.
// `DISP_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority, lowest index wins.
module disp_arbiter #(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          disp_data,
  output logic [1:0]           owner,
  output logic                 busy
);

  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_HOLD   = 1'b1;
  localparam logic [24:0]     HOLD_LOAD = 25'(HOLD_CYCLES - 1);
  localparam logic [1:0]      LAST_IDX  = 2'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

  logic [0:0]      state;
  logic [24:0]     cnt;
  logic [NREQ-1:0] req_eff;
  logic [1:0]      start_idx;
  logic [1:0]      scan_idx;
  logic [1:0]      win_idx;
  logic            win_vld;
  logic            own_req;

  // A requester is not considered again in the cycle its grant is visible.
  assign req_eff = req & ~gnt;
  assign own_req = req_eff[owner];
  assign busy    = (state == ST_HOLD);

`ifdef DISP_ARB_RR_EN
  logic [1:0] rr_ptr;

  assign start_idx = rr_ptr;

  // Pointer moves only on IDLE grants so refreshes cannot shift fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'd0;
    end else if (state == ST_IDLE && win_vld) begin
      rr_ptr <= (win_idx == LAST_IDX) ? 2'd0 : win_idx + 2'd1;
    end
  end
`else
  assign start_idx = 2'd0;
`endif

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = 2'd0;
    scan_idx = start_idx;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req_eff[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? 2'd0 : scan_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gnt       <= '0;
      disp_data <= '0;
      owner     <= 2'd0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            disp_data <= req_data[32*win_idx +: 32];
            owner     <= win_idx;
            gnt       <= ONE_HOT0 << win_idx;
            cnt       <= HOLD_LOAD;
            state     <= ST_HOLD;
          end
        end
        default: begin
          // Owner refresh updates data but never restarts the hold window.
          if (own_req) begin
            disp_data <= req_data[32*owner +: 32];
            gnt       <= ONE_HOT0 << owner;
          end
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 25'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter (NREQ=3, HOLD_CYCLES=8), vector table plus scoreboard queues.
module tb_disp_arbiter;

  localparam int NREQ = 3;
  localparam int HOLD = 8;
  localparam logic [31:0] NZ0 = 32'h0BAD_0000;
  localparam logic [31:0] NZ1 = 32'h0BAD_0001;
  localparam logic [31:0] NZ2 = 32'h0BAD_0002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [95:0] req_data = '0;
  logic [2:0]  gnt;
  logic [31:0] disp_data;
  logic [1:0]  owner;
  logic        busy;

  always #5 clk = ~clk;

  disp_arbiter #(.NREQ(NREQ), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .disp_data (disp_data),
    .owner     (owner),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    int          n;
    logic [2:0]  gnt;
    logic [31:0] dat;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [2:0]  gnt;
    logic [31:0] dat;
    logic [1:0]  own;
    logic        busy;
  } exp_t;

  typedef struct {
    int idx;
    int gap;
  } gexp_t;

  vec_t        vt[19];
  exp_t        sb[$];
  gexp_t       gq[$];
  logic [31:0] cdat[3];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc, last, got, gi;
  gexp_t       ge;

  function automatic vec_t mk(input logic [2:0] r, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input int n, input logic [2:0] g,
                              input logic [31:0] dat, input logic [1:0] own, input logic b);
    vec_t v;
    v.req = r; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.n = n;
    v.gnt = g; v.dat = dat; v.own = own; v.busy = b;
    return v;
  endfunction

  function automatic exp_t mke(input logic [2:0] g, input logic [31:0] dat, input logic [1:0] own,
                               input logic b);
    exp_t e;
    e.gnt = g; e.dat = dat; e.own = own; e.busy = b;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".gnt"},   {29'd0, gnt},   {29'd0, e.gnt});
      chk({tag, ".data"},  disp_data,      e.dat);
      chk({tag, ".owner"}, {30'd0, owner}, {30'd0, e.own});
      chk({tag, ".busy"},  {31'd0, busy},  {31'd0, e.busy});
    end
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int c = 0; c < vt[i].n; c++) begin
        @(negedge clk);
        req      = vt[i].req;
        req_data = {vt[i].d2, vt[i].d1, vt[i].d0};
        sb.push_back(mke(vt[i].gnt, vt[i].dat, vt[i].own, vt[i].busy));
        @(posedge clk);
        #1;
        check_outputs($sformatf("row%0d_c%0d", i, c));
      end
    end
  endtask

  initial begin
    // single grant
    vt[0]  = mk(3'b010, NZ0, 32'hDEAD_BEEF, NZ2, 1, 3'b010, 32'hDEAD_BEEF, 2'd1, 1'b1);
    vt[1]  = mk(3'b000, NZ0, NZ1, NZ2,          7, 3'b000, 32'hDEAD_BEEF, 2'd1, 1'b1);
    vt[2]  = mk(3'b000, NZ0, NZ1, NZ2,          2, 3'b000, 32'hDEAD_BEEF, 2'd1, 1'b0);
    // non-owner request waits for the IDLE cycle
    vt[3]  = mk(3'b010, NZ0, 32'h1111_1111, NZ2, 1, 3'b010, 32'h1111_1111, 2'd1, 1'b1);
    vt[4]  = mk(3'b001, 32'hA0A0_A0A0, NZ1, NZ2, 7, 3'b000, 32'h1111_1111, 2'd1, 1'b1);
    vt[5]  = mk(3'b001, 32'hA0A0_A0A0, NZ1, NZ2, 1, 3'b000, 32'h1111_1111, 2'd1, 1'b0);
    vt[6]  = mk(3'b001, 32'hA0A0_A0A0, NZ1, NZ2, 1, 3'b001, 32'hA0A0_A0A0, 2'd0, 1'b1);
    vt[7]  = mk(3'b000, NZ0, NZ1, NZ2,           7, 3'b000, 32'hA0A0_A0A0, 2'd0, 1'b1);
    vt[8]  = mk(3'b000, NZ0, NZ1, NZ2,           1, 3'b000, 32'hA0A0_A0A0, 2'd0, 1'b0);
    // owner refresh mid-hold and on the expiry edge
    vt[9]  = mk(3'b100, NZ0, NZ1, 32'h2222_2222, 1, 3'b100, 32'h2222_2222, 2'd2, 1'b1);
    vt[10] = mk(3'b000, NZ0, NZ1, NZ2,           4, 3'b000, 32'h2222_2222, 2'd2, 1'b1);
    vt[11] = mk(3'b100, NZ0, NZ1, 32'h0000_00AA, 1, 3'b100, 32'h0000_00AA, 2'd2, 1'b1);
    vt[12] = mk(3'b000, NZ0, NZ1, NZ2,           2, 3'b000, 32'h0000_00AA, 2'd2, 1'b1);
    vt[13] = mk(3'b100, NZ0, NZ1, 32'h0000_00BB, 1, 3'b100, 32'h0000_00BB, 2'd2, 1'b0);
    vt[14] = mk(3'b000, NZ0, NZ1, NZ2,           2, 3'b000, 32'h0000_00BB, 2'd2, 1'b0);
    // grant that is interrupted by reset
    vt[15] = mk(3'b001, 32'h1234_5678, NZ1, NZ2, 1, 3'b001, 32'h1234_5678, 2'd0, 1'b1);
    vt[16] = mk(3'b000, NZ0, NZ1, NZ2,           2, 3'b000, 32'h1234_5678, 2'd0, 1'b1);
    // after reset release
    vt[17] = mk(3'b000, NZ0, NZ1, NZ2,           1, 3'b000, 32'h0,         2'd0, 1'b0);
    vt[18] = mk(3'b100, NZ0, NZ1, 32'hCAFE_F00D, 1, 3'b100, 32'hCAFE_F00D, 2'd2, 1'b1);

    cdat[0] = 32'hC0C0_0000;
    cdat[1] = 32'hC1C1_0001;
    cdat[2] = 32'hC2C2_0002;

    // reset state
    repeat (3) @(negedge clk);
    sb.push_back(mke(3'b000, 32'h0, 2'd0, 1'b0));
    check_outputs("reset");
    rst = 1'b0;

    // contention: requesters drop on their grant and re-raise once the display is free
`ifdef DISP_ARB_RR_EN
    gq.push_back('{idx: 0, gap: 1});
    gq.push_back('{idx: 1, gap: HOLD + 1});
    gq.push_back('{idx: 2, gap: HOLD + 1});
    gq.push_back('{idx: 0, gap: HOLD + 1});
`else
    gq.push_back('{idx: 0, gap: 1});
    gq.push_back('{idx: 0, gap: HOLD + 1});
    gq.push_back('{idx: 0, gap: HOLD + 1});
    gq.push_back('{idx: 0, gap: HOLD + 1});
`endif
    @(negedge clk);
    req_data = {cdat[2], cdat[1], cdat[0]};
    req      = 3'b111;
    cyc = 0; last = 0; got = 0;
    for (int t = 0; t < 60 && got < 4; t++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (gnt != 3'b000) begin
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gi = i;
        chk("cont_onehot", $countones(gnt), 1);
        chk("cont_data", disp_data, cdat[gi]);
        if (gq.size() > 0) begin
          ge = gq.pop_front();
          chk($sformatf("cont_idx%0d", got), gi, ge.idx);
          chk($sformatf("cont_gap%0d", got), cyc - last, ge.gap);
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!busy) req[i] = 1'b1;
      end
    end
    while (gq.size() > 0) begin
      ge = gq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL cont_missing: got no grant, want grant to %0d", ge.idx);
    end
    req = 3'b000;
    repeat (HOLD + 4) @(negedge clk);

    apply_rows(0, 16);

    // asynchronous reset in the middle of a hold window
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.push_back(mke(3'b000, 32'h0, 2'd0, 1'b0));
    check_outputs("rst_mid_hold");
    @(posedge clk);
    #1;
    sb.push_back(mke(3'b000, 32'h0, 2'd0, 1'b0));
    check_outputs("rst_held");
    rst = 1'b0;

    apply_rows(17, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
